// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared defaults and helpers for the parametrised pattern
//               detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int          c_DEF_PAT_W   = 3;
    localparam logic [15:0] c_DEF_PATTERN = 16'b0000_0000_0000_0101;
    localparam int          c_DEF_CNT_W   = 8;

    // Width needed to hold a fill level of 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_counter.sv
// ============================================================================
// Module      : seq_match_counter
// Description : Saturating match counter; holds at all-ones and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = c_DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc_i && (cnt_q != c_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
            sat_d = (cnt_d == c_MAX);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module      : seq_detector_param
// Description : Parametrised serial pattern detector with run-time overlap
//               selection. Define SEQ_DET_CNT_EN to add the saturating
//               match counter and its match_cnt_o / cnt_sat_o ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = c_DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = c_DEF_PATTERN[PAT_W-1:0],
    parameter int               CNT_W   = c_DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             x_valid_i,
    input  logic             x_i,
    input  logic             overlap_i,
    output logic             z_o
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             cnt_sat_o
`endif
);

    localparam int                  c_FILL_W = fill_width(PAT_W);
    localparam logic [c_FILL_W-1:0] c_FULL   = c_FILL_W'(PAT_W);

    if ((PAT_W < 2) || (PAT_W > 16)) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W must be within 2..16");
    end
    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be within 1..32");
    end

    // The oldest history bit is shifted out before it is ever compared, so
    // only the newest PAT_W-1 accepted bits need storage.
    logic [PAT_W-2:0]    hist_q, hist_d;
    logic [c_FILL_W-1:0] fill_q, fill_d;
    logic                z_q, z_d;

    logic [PAT_W-1:0]    w_win;
    logic [c_FILL_W-1:0] w_fill_n;
    logic                w_accept;
    logic                w_hit;

    assign w_win    = {hist_q, x_i};
    assign w_fill_n = (fill_q == c_FULL) ? fill_q : fill_q + c_FILL_W'(1);
    assign w_accept = x_valid_i && !clr_i;
    assign w_hit    = w_accept && (w_fill_n == c_FULL) && (w_win == PATTERN);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = 1'b0;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid_i) begin
            hist_d = w_win[PAT_W-2:0];
            fill_d = (w_hit && !overlap_i) ? '0 : w_fill_n;
            z_d    = w_hit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    assign z_o = z_q;

`ifdef SEQ_DET_CNT_EN
    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_hit),
        .clr_i  (clr_i),
        .cnt_o  (match_cnt_o),
        .sat_o  (cnt_sat_o)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench for seq_detector_param (vector table,
//               directed corner cases and a queue-based random model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst_n, clr, x_valid, x, overlap;
    logic z_a, z_b;
`ifdef SEQ_DET_CNT_EN
    logic [7:0] cnt_a;
    logic       sat_a;
    logic       z_c;
    logic [1:0] cnt_c;
    logic       sat_c;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detector_param u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .x_valid_i   (x_valid),
        .x_i         (x),
        .overlap_i   (overlap),
        .z_o         (z_a)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt_o (cnt_a),
        .cnt_sat_o   (sat_a)
`endif
    );

    seq_detector_param #(
        .PAT_W   (2),
        .PATTERN (2'b11)
    ) u_dut11 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .x_valid_i   (x_valid),
        .x_i         (x),
        .overlap_i   (overlap),
        .z_o         (z_b)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt_o (),
        .cnt_sat_o   ()
`endif
    );

`ifdef SEQ_DET_CNT_EN
    seq_detector_param #(
        .CNT_W (2)
    ) u_sat (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .x_valid_i   (x_valid),
        .x_i         (x),
        .overlap_i   (overlap),
        .z_o         (z_c),
        .match_cnt_o (cnt_c),
        .cnt_sat_o   (sat_c)
    );
`endif

    typedef struct packed {
        logic clr;
        logic vld;
        logic x;
        logic ov;
        logic ez;
    } vec_t;

    typedef bit bitq_t[$];

    vec_t  tbl[$];
    bitq_t q_a, q_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic xi, input logic ov);
        clr     = c;
        x_valid = v;
        x       = xi;
        overlap = ov;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic v, input logic xi,
                                input logic ov, input logic ez);
        vec_t r;
        r.clr = c; r.vld = v; r.x = xi; r.ov = ov; r.ez = ez;
        return r;
    endfunction

    // Bits and expected pulses are written left-to-right in stream order.
    task automatic add_stream(input logic [15:0] bits, input logic [15:0] zs,
                              input int n, input logic ov);
        for (int i = 0; i < n; i++)
            tbl.push_back(mk(1'b0, 1'b1, bits[n-1-i], ov, zs[n-1-i]));
    endtask

    // Reference: the accepted bits since the last restart; a match is the
    // newest w bits equal to the pattern with at least w bits on record.
    function automatic bit pat_hit(input bitq_t q, input int w, input logic [15:0] pat);
        if (q.size() < w) return 1'b0;
        for (int i = 0; i < w; i++)
            if (q[q.size()-w+i] != pat[w-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        int exp_cnt;
        logic c, v, xi, ov, ez_a, ez_b;
        int cnt_m;

        rst_n = 1'b0; clr = 1'b0; x_valid = 1'b0; x = 1'b0; overlap = 1'b1;
        #12;
        chk("reset_z", z_a, 0);
        chk("reset_z11", z_b, 0);
`ifdef SEQ_DET_CNT_EN
        chk("reset_cnt", cnt_a, 0);
        chk("reset_sat", sat_a, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- vector table ----------------
        add_stream(16'b10110100101, 16'b00100100001, 11, 1'b1);
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        add_stream(16'b10101, 16'b00101, 5, 1'b1);
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        add_stream(16'b10101, 16'b00100, 5, 1'b0);
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        add_stream(16'b10, 16'b00, 2, 1'b1);
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        add_stream(16'b101, 16'b001, 3, 1'b1);

        exp_cnt = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].clr, tbl[i].vld, tbl[i].x, tbl[i].ov);
            exp_cnt = tbl[i].clr ? 0 : exp_cnt + int'(tbl[i].ez);
            chk($sformatf("tbl_z[%0d]", i), z_a, tbl[i].ez);
`ifdef SEQ_DET_CNT_EN
            chk($sformatf("tbl_cnt[%0d]", i), cnt_a, exp_cnt);
`endif
        end

        // ---------------- pattern 11: back-to-back in overlap mode ----------------
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1); chk("ov11_b0", z_b, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1); chk("ov11_b1", z_b, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1); chk("ov11_b2", z_b, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0); chk("nov11_b0", z_b, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0); chk("nov11_b1", z_b, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0); chk("nov11_b2", z_b, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0); chk("nov11_b3", z_b, 1);

`ifdef SEQ_DET_CNT_EN
        // ---------------- saturation with CNT_W=2 ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int m = 1; m <= 4; m++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("sat_z[%0d]", m), z_c, 1);
            chk($sformatf("sat_cnt[%0d]", m), cnt_c, (m > 3) ? 3 : m);
            chk($sformatf("sat_flag[%0d]", m), sat_c, (m >= 3) ? 1 : 0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_clr_cnt", cnt_c, 0);
        chk("sat_clr_flag", sat_c, 0);
`endif

        // ---------------- random stimulus vs queue model ----------------
        cnt_m = 0;
        for (int n = 0; n < 3000; n++) begin
            c  = (n == 0) || ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            xi = 1'($urandom);
            ov = ($urandom_range(0, 2) != 0);
            ez_a = 1'b0;
            ez_b = 1'b0;
            if (c) begin
                q_a.delete();
                q_b.delete();
                cnt_m = 0;
            end else if (v) begin
                q_a.push_back(xi);
                ez_a = pat_hit(q_a, 3, 16'b101);
                if (ez_a && !ov) q_a.delete();
                else if (q_a.size() > 3) void'(q_a.pop_front());
                q_b.push_back(xi);
                ez_b = pat_hit(q_b, 2, 16'b11);
                if (ez_b && !ov) q_b.delete();
                else if (q_b.size() > 2) void'(q_b.pop_front());
                if (ez_a && cnt_m < 255) cnt_m++;
            end
            step(c, v, xi, ov);
            chk("rand_z101", z_a, ez_a);
            chk("rand_z11", z_b, ez_b);
`ifdef SEQ_DET_CNT_EN
            chk("rand_cnt", cnt_a, cnt_m);
            chk("rand_sat", sat_a, (cnt_m == 255) ? 1 : 0);
`endif
        end

        // ---------------- asynchronous reset ----------------
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("pre_rst_z", z_a, 1);
        x_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_z", z_a, 0);
`ifdef SEQ_DET_CNT_EN
        chk("async_rst_cnt", cnt_a, 0);
        chk("async_rst_sat", sat_a, 0);
`endif
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_z", z_a, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("post_rst_no_match", z_a, 0);
`ifdef SEQ_DET_CNT_EN
        chk("post_rst_cnt", cnt_a, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
